// File: rtl/z80fi_insn_collector_pkg.sv
// Shared constants and state encoding for the Z80FI instruction collector.
`default_nettype none

package z80fi_insn_collector_pkg;

   localparam int MAX_BYTES = 4;
   localparam int LEN_W     = 3;
   localparam int INSN_W    = 8 * MAX_BYTES;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DISCARD = 2'd2
   } state_e;

endpackage

`default_nettype wire

// File: rtl/z80fi_insn_collector_if.sv
// Fetch-stream inputs and retirement outputs between the core and the collector.
`default_nettype none

interface z80fi_insn_collector_if;
   import z80fi_insn_collector_pkg::*;

   logic                byte_valid;
   logic                byte_first;
   logic [7:0]          byte_data;
   logic [15:0]         byte_pc;
   logic                insn_done;

   logic                z80fi_valid;
   logic [INSN_W-1:0]   z80fi_insn;
   logic [LEN_W-1:0]    z80fi_insn_len;
   logic [15:0]         z80fi_pc_rdata;
   logic [15:0]         z80fi_order;
   logic                fetch_err;

   modport master (
      output byte_valid, byte_first, byte_data, byte_pc, insn_done,
      input  z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_pc_rdata,
             z80fi_order, fetch_err
   );

   modport slave (
      input  byte_valid, byte_first, byte_data, byte_pc, insn_done,
      output z80fi_valid, z80fi_insn, z80fi_insn_len, z80fi_pc_rdata,
             z80fi_order, fetch_err
   );

endinterface

`default_nettype wire

// File: rtl/z80fi_insn_collector.sv
// Assembles fetched instruction bytes little-endian and emits one registered
// retirement record per instruction, flagging malformed fetch sequences.
`default_nettype none

module z80fi_insn_collector
   import z80fi_insn_collector_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset_n,
   z80fi_insn_collector_if.slave    bus
);

   state_e              state_q, state_d;
   logic [INSN_W-1:0]   buf_q, buf_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic [15:0]         pc0_q, pc0_d;

   logic                valid_q, valid_d;
   logic                err_q, err_d;
   logic [INSN_W-1:0]   insn_q, insn_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [15:0]         pc_q, pc_d;
   logic [15:0]         order_q, order_d;

   logic                first_w;
   logic                retire_w;

   assign first_w = bus.byte_valid & bus.byte_first;

   always_comb begin
      state_d  = state_q;
      buf_d    = buf_q;
      cnt_d    = cnt_q;
      pc0_d    = pc0_q;
      err_d    = 1'b0;
      retire_w = 1'b0;

      if (first_w) begin
         // A new first byte while an instruction is still open abandons it.
         err_d   = (state_q != ST_IDLE);
         buf_d   = {{(INSN_W-8){1'b0}}, bus.byte_data};
         cnt_d   = LEN_W'(1);
         pc0_d   = bus.byte_pc;
         state_d = ST_COLLECT;
         if (bus.insn_done) begin
            retire_w = 1'b1;
            state_d  = ST_IDLE;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               err_d = bus.byte_valid | bus.insn_done;
            end
            ST_COLLECT: begin
               if (bus.byte_valid) begin
                  if (cnt_q < LEN_W'(MAX_BYTES)) begin
                     for (int i = 0; i < MAX_BYTES; i++) begin
                        if (cnt_q == LEN_W'(i)) buf_d[8*i +: 8] = bus.byte_data;
                     end
                     cnt_d = cnt_q + LEN_W'(1);
                  end else begin
                     err_d   = 1'b1;
                     state_d = ST_DISCARD;
                  end
               end
               // An overflowing byte in the retirement cycle kills the record.
               if (bus.insn_done) begin
                  retire_w = ~err_d;
                  state_d  = ST_IDLE;
               end
            end
            ST_DISCARD: begin
               if (bus.insn_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      valid_d = retire_w;
      insn_d  = retire_w ? buf_d : insn_q;
      len_d   = retire_w ? cnt_d : len_q;
      pc_d    = retire_w ? pc0_d : pc_q;
      order_d = retire_w ? order_q + 16'd1 : order_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         buf_q   <= '0;
         cnt_q   <= '0;
         pc0_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         insn_q  <= '0;
         len_q   <= '0;
         pc_q    <= '0;
         order_q <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         pc0_q   <= pc0_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         insn_q  <= insn_d;
         len_q   <= len_d;
         pc_q    <= pc_d;
         order_q <= order_d;
      end
   end

   assign bus.z80fi_valid    = valid_q;
   assign bus.fetch_err      = err_q;
   assign bus.z80fi_insn     = insn_q;
   assign bus.z80fi_insn_len = len_q;
   assign bus.z80fi_pc_rdata = pc_q;
   assign bus.z80fi_order    = order_q;

endmodule

`default_nettype wire

// File: tb/tb_z80fi_insn_collector.sv
// Scoreboard bench: a byte-queue reference model predicts retirements and
// fetch errors; a negedge monitor compares them against the collector.
`default_nettype none

module tb_z80fi_insn_collector;
   import z80fi_insn_collector_pkg::*;

   typedef struct {
      int          cyc;
      logic [31:0] insn;
      logic [2:0]  len;
      logic [15:0] pc;
      logic [15:0] order;
   } ret_t;

   logic clk;
   logic reset_n;
   int   cyc;
   int   n_checks;
   int   n_pass;

   z80fi_insn_collector_if bus ();

   z80fi_insn_collector dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   // Reference model state: bytes of the open instruction kept in a queue.
   logic [7:0]  m_bytes[$];
   bit          m_active;
   bit          m_disc;
   logic [15:0] m_pc;
   logic [15:0] m_order;
   ret_t        ret_q[$];
   int          err_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic model_retire(input int tag);
      ret_t r;
      r.cyc  = tag;
      r.insn = '0;
      foreach (m_bytes[i]) r.insn = r.insn | (32'(m_bytes[i]) << (8 * i));
      r.len  = 3'(m_bytes.size());
      r.pc   = m_pc;
      m_order = m_order + 16'd1;
      r.order = m_order;
      ret_q.push_back(r);
   endtask

   task automatic model_step(input bit v, input bit f, input logic [7:0] d,
                             input logic [15:0] pc, input bit done, input int tag);
      bit err;
      err = 1'b0;
      if (v && f) begin
         err = m_active;
         m_bytes.delete();
         m_bytes.push_back(d);
         m_pc     = pc;
         m_active = 1'b1;
         m_disc   = 1'b0;
         if (done) begin
            model_retire(tag);
            m_active = 1'b0;
         end
      end else if (!m_active) begin
         err = v || done;
      end else if (m_disc) begin
         if (done) m_active = 1'b0;
      end else begin
         if (v) begin
            if (m_bytes.size() < MAX_BYTES) m_bytes.push_back(d);
            else begin
               err    = 1'b1;
               m_disc = 1'b1;
            end
         end
         if (done) begin
            if (!m_disc) model_retire(tag);
            m_active = 1'b0;
         end
      end
      if (err) err_q.push_back(tag);
   endtask

   task automatic model_reset();
      m_bytes.delete();
      m_active = 1'b0;
      m_disc   = 1'b0;
      m_pc     = '0;
      m_order  = '0;
      ret_q.delete();
      err_q.delete();
   endtask

   // Drive one cycle of stimulus, record the prediction, advance past the edge.
   task automatic step(input bit v, input bit f, input logic [7:0] d,
                       input logic [15:0] pc, input bit done);
      bus.byte_valid = v;
      bus.byte_first = f;
      bus.byte_data  = d;
      bus.byte_pc    = pc;
      bus.insn_done  = done;
      model_step(v, f, d, pc, done, cyc + 1);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_valid"}, 64'(bus.z80fi_valid), 64'd0);
      chk({tag, "_err"},   64'(bus.fetch_err),   64'd0);
      chk({tag, "_insn"},  64'(bus.z80fi_insn),  64'd0);
      chk({tag, "_len"},   64'(bus.z80fi_insn_len), 64'd0);
      chk({tag, "_pc"},    64'(bus.z80fi_pc_rdata), 64'd0);
      chk({tag, "_order"}, 64'(bus.z80fi_order), 64'd0);
   endtask

   // Monitor: consumes predictions exactly on the cycle they are due.
   always @(negedge clk) begin
      if (reset_n) begin
         if (ret_q.size() > 0 && ret_q[0].cyc == cyc) begin
            ret_t e;
            e = ret_q.pop_front();
            chk("valid", 64'(bus.z80fi_valid), 64'd1);
            chk("insn",  64'(bus.z80fi_insn),  64'(e.insn));
            chk("len",   64'(bus.z80fi_insn_len), 64'(e.len));
            chk("pc",    64'(bus.z80fi_pc_rdata), 64'(e.pc));
            chk("order", 64'(bus.z80fi_order), 64'(e.order));
         end else if (bus.z80fi_valid) begin
            chk("spurious_valid", 64'd1, 64'd0);
         end
         if (err_q.size() > 0 && err_q[0] == cyc) begin
            void'(err_q.pop_front());
            chk("fetch_err", 64'(bus.fetch_err), 64'd1);
         end else if (bus.fetch_err) begin
            chk("spurious_fetch_err", 64'd1, 64'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: cycle %0d reached, expected completion", cyc);
      $fatal(1);
   end

   initial begin
      bit          v, f, done;
      logic [7:0]  d;
      logic [15:0] pc;
      n_checks = 0;
      n_pass   = 0;
      reset_n  = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_first = 1'b0;
      bus.byte_data  = '0;
      bus.byte_pc    = '0;
      bus.insn_done  = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_zero_outputs("reset");
      reset_n = 1'b1;

      // LD BC,1234h
      step(1, 1, 8'h01, 16'h0100, 0);
      step(1, 0, 8'h34, 16'h0101, 0);
      step(1, 0, 8'h12, 16'h0102, 1);
      // NOP retiring in its own fetch cycle, back-to-back
      step(1, 1, 8'h00, 16'h0200, 1);
      // LD (IX+5),7Fh with insn_done alone
      step(1, 1, 8'hDD, 16'h0300, 0);
      step(1, 0, 8'h36, 16'h0301, 0);
      step(1, 0, 8'h05, 16'h0302, 0);
      step(1, 0, 8'h7F, 16'h0303, 0);
      step(0, 0, 8'h00, 16'h0000, 1);
      // Overflow, then discard until insn_done, then a normal instruction
      step(1, 1, 8'hED, 16'h0400, 0);
      for (int i = 0; i < 4; i++) step(1, 0, 8'(8'hA0 + i), 16'(16'h0401 + i), 0);
      step(1, 0, 8'hEE, 16'h0405, 0);
      step(0, 0, 8'h00, 16'h0000, 1);
      step(1, 1, 8'h3C, 16'h0500, 1);
      // Abandon an open instruction with a new one-byte instruction
      step(1, 1, 8'h3E, 16'h0600, 0);
      step(1, 1, 8'h00, 16'h0602, 1);
      // Protocol errors from IDLE
      step(1, 0, 8'h55, 16'h0700, 0);
      step(0, 0, 8'h00, 16'h0000, 1);
      step(0, 0, 8'h00, 16'h0000, 0);

      // Reset mid-collection loses the partial instruction
      step(1, 1, 8'h21, 16'h0800, 0);
      step(1, 0, 8'h34, 16'h0801, 0);
      bus.byte_valid = 1'b0;
      bus.insn_done  = 1'b0;
      reset_n = 1'b0;
      model_reset();
      #2;
      chk_zero_outputs("midreset");
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step(1, 1, 8'h00, 16'h0900, 1);

      // Randomized fetch streams
      for (int n = 0; n < 1500; n++) begin
         v    = ($urandom_range(0, 99) < 75);
         f    = v && ($urandom_range(0, 99) < (m_active ? 12 : 85));
         done = ($urandom_range(0, 99) < (m_active ? 30 : 4));
         d    = 8'($urandom);
         pc   = 16'($urandom);
         if (v && !f && done && m_active && !m_disc && m_bytes.size() == MAX_BYTES) done = 1'b0;
         step(v, f, d, pc, done);
      end

      repeat (3) step(0, 0, 8'h00, 16'h0000, 0);
      chk("ret_queue_drained", 64'(ret_q.size()), 64'd0);
      chk("err_queue_drained", 64'(err_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
